// File: rtl/hydra_pkg.sv
// Shared definitions for the port frontends: half-word layout, header field
// positions, read-side FSM states and the FIFO entry format.
package hydra_pkg;

   localparam int HW_W    = 16;
   localparam int LEN_MSB = 15;
   localparam int LEN_LSB = 7;
   localparam int PORT_W  = 4;
   localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      EOP
   } rd_state_t;

   // One buffered half-word plus its end-of-packet tag.
   typedef struct packed {
      logic            eop;
      logic [HW_W-1:0] data;
   } fifo_ent_t;

   // Packet length in half-words, carried by the first half-word.
   function automatic logic [LEN_W-1:0] hdr_len_f(input logic [HW_W-1:0] hw);
      return hw[LEN_MSB:LEN_LSB];
   endfunction

   // Destination port, carried by the first half-word.
   function automatic logic [PORT_W-1:0] hdr_port_f(input logic [HW_W-1:0] hw);
      return hw[PORT_W-1:0];
   endfunction

endpackage

// File: rtl/port_rd_fifo.sv
// Synchronous FIFO between the read backend and the egress FSM.
// Pointers wrap naturally; the count is one bit wider so full and empty
// are unambiguous. A push while full is dropped and latches a sticky flag.
module port_rd_fifo
   import hydra_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_req,
   input  fifo_ent_t                wr_ent,
   input  logic                     pop,
   output fifo_ent_t                rd_ent,
   output logic [$clog2(DEPTH):0]   cnt,
   output logic                     empty,
   output logic                     ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fifo_ent_t        mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             full;
   logic             push;
   logic             pop_ok;

   assign full   = (cnt == CW'(DEPTH));
   assign empty  = (cnt == '0);
   assign push   = push_req && !full;
   assign pop_ok = pop && !empty;

   // Head entry is presented combinationally; the consumer registers it.
   assign rd_ent = mem[rptr];

   // Storage array: written on accepted pushes only, never reset.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wr_ent;
   end

   // Pointers, occupancy and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
         ovf  <= 1'b0;
      end else begin
         if (push)   wptr <= wptr + AW'(1);
         if (pop_ok) rptr <= rptr + AW'(1);
         case ({push, pop_ok})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
         if (push_req && full) ovf <= 1'b1;
      end
   end

endmodule

// File: rtl/port_rd_frontend.sv
// Read-side port frontend: buffers backend half-words and replays them as
// sop / vld beats / eop framing. The first beat of each packet supplies the
// destination and length; the beat count is checked against that length.
module port_rd_frontend
   import hydra_pkg::*;
#(
   parameter int DEPTH    = 64,
   parameter int PAUSE_TH = 61
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              xfer_data_vld,
   input  logic [HW_W-1:0]   xfer_data,
   input  logic              end_of_packet,
   output logic              xfer_pause,
   input  logic              rd_ready,
   output logic              rd_sop,
   output logic              rd_vld,
   output logic [HW_W-1:0]   rd_data,
   output logic              rd_eop,
   output logic [PORT_W-1:0] rd_dest,
   output logic              len_err,
   output logic              ovf
);

   localparam int CW = $clog2(DEPTH) + 1;

   fifo_ent_t         wr_ent;
   fifo_ent_t         rd_ent;
   logic [CW-1:0]     cnt;
   logic              empty;
   logic              pop;

   rd_state_t         state;
   logic [LEN_W-1:0]  hdr_len;
   logic              hdr_vld;
   logic [LEN_W-1:0]  beat_cnt;
   logic [LEN_W-1:0]  beat_nxt;
   logic [LEN_W-1:0]  cur_len;
   logic              mism;
   logic              len_bad;

   assign wr_ent = '{eop: end_of_packet, data: xfer_data};

   port_rd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_req (xfer_data_vld),
      .wr_ent   (wr_ent),
      .pop      (pop),
      .rd_ent   (rd_ent),
      .cnt      (cnt),
      .empty    (empty),
      .ovf      (ovf)
   );

   // A beat leaves the FIFO only in DATA with data present and the port ready.
   assign pop = (state == DATA) && !empty && rd_ready;

   // On the header beat the length is taken straight from the entry, so a
   // single-entry packet is checked against its own header.
   assign beat_nxt = beat_cnt + LEN_W'(1);
   assign cur_len  = hdr_vld ? hdr_len : hdr_len_f(rd_ent.data);
   assign mism     = (beat_nxt != cur_len) || (cur_len == '0);

   // Egress framing FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rd_sop   <= 1'b0;
         rd_vld   <= 1'b0;
         rd_data  <= '0;
         rd_eop   <= 1'b0;
         rd_dest  <= '0;
         len_err  <= 1'b0;
         hdr_len  <= '0;
         hdr_vld  <= 1'b0;
         beat_cnt <= '0;
         len_bad  <= 1'b0;
      end else begin
         rd_sop  <= 1'b0;
         rd_vld  <= 1'b0;
         rd_eop  <= 1'b0;
         len_err <= 1'b0;
         case (state)
            IDLE: begin
               beat_cnt <= '0;
               hdr_vld  <= 1'b0;
               if (!empty && rd_ready) begin
                  rd_sop <= 1'b1;
                  state  <= DATA;
               end
            end
            DATA: begin
               if (pop) begin
                  rd_vld   <= 1'b1;
                  rd_data  <= rd_ent.data;
                  beat_cnt <= beat_nxt;
                  if (!hdr_vld) begin
                     hdr_len <= hdr_len_f(rd_ent.data);
                     rd_dest <= hdr_port_f(rd_ent.data);
                     hdr_vld <= 1'b1;
                  end
                  if (rd_ent.eop) begin
                     len_bad <= mism;
                     state   <= EOP;
                  end
               end
            end
            EOP: begin
               rd_eop  <= 1'b1;
               len_err <= len_bad;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Backpressure leaves a few slots of margin for the backend's reaction time.
   always_ff @(posedge clk) begin
      if (rst) xfer_pause <= 1'b0;
      else     xfer_pause <= (cnt >= CW'(PAUSE_TH));
   end

endmodule

// File: tb/tb_port_rd_frontend.sv
// Bench for port_rd_frontend: directed framing sequences, a table of header /
// beat-count vectors, and a randomized phase against a queue-based scoreboard.
module tb_port_rd_frontend;
   import hydra_pkg::*;

   localparam int DEPTH    = 64;
   localparam int PAUSE_TH = 61;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        xfer_data_vld = 1'b0;
   logic [15:0] xfer_data = '0;
   logic        end_of_packet = 1'b0;
   logic        rd_ready = 1'b0;
   logic        xfer_pause, rd_sop, rd_vld, rd_eop, len_err, ovf;
   logic [15:0] rd_data;
   logic [3:0]  rd_dest;

   always #5 clk = ~clk;

   port_rd_frontend #(.DEPTH(DEPTH), .PAUSE_TH(PAUSE_TH)) dut (
      .clk(clk), .rst(rst), .xfer_data_vld(xfer_data_vld), .xfer_data(xfer_data),
      .end_of_packet(end_of_packet), .xfer_pause(xfer_pause), .rd_ready(rd_ready),
      .rd_sop(rd_sop), .rd_vld(rd_vld), .rd_data(rd_data), .rd_eop(rd_eop),
      .rd_dest(rd_dest), .len_err(len_err), .ovf(ovf)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] hdr_w(input int len, input int dest);
      return {9'(len), 3'b000, 4'(dest)};
   endfunction

   // ---------------- scoreboard ----------------
   logic [16:0] q[$];
   logic [16:0] m_ent;
   logic [15:0] m_hdr;
   logic        s_rst, s_v, s_e, s_rdy;
   logic [15:0] s_d;
   int          m_occ, m_beats;
   bit          in_pkt, eop_due, exp_eop, exp_le, ovf_m;
   int          pkts_done = 0, last_beats = 0;
   bit          last_le;
   logic [3:0]  last_dest;

   always @(posedge clk) begin
      s_rst = rst; s_v = xfer_data_vld; s_e = end_of_packet; s_d = xfer_data; s_rdy = rd_ready;
      #1;
      m_occ = q.size();
      if (s_rst) begin
         chk("rst_sop", rd_sop, 0);   chk("rst_vld", rd_vld, 0);
         chk("rst_data", rd_data, 0); chk("rst_eop", rd_eop, 0);
         chk("rst_dest", rd_dest, 0); chk("rst_len_err", len_err, 0);
         chk("rst_ovf", ovf, 0);      chk("rst_pause", xfer_pause, 0);
         q.delete();
         in_pkt = 0; eop_due = 0; ovf_m = 0; m_beats = 0;
      end else begin
         chk("pause", xfer_pause, m_occ >= PAUSE_TH);
         if (s_v && m_occ == DEPTH) ovf_m = 1;
         chk("ovf", ovf, ovf_m);
         exp_eop = eop_due;
         eop_due = 0;
         chk("eop", rd_eop, exp_eop);
         if (exp_eop) begin
            chk("len_err", len_err, exp_le);
            chk("dest", rd_dest, m_hdr[3:0]);
            pkts_done++;
            last_le = len_err; last_dest = rd_dest; last_beats = m_beats;
            in_pkt = 0;
         end else begin
            chk("len_err_quiet", len_err, 0);
         end
         if (rd_sop) begin
            chk("sop_in_pkt", in_pkt, 0);
            chk("sop_with_vld", rd_vld, 0);
            in_pkt = 1;
            m_beats = 0;
         end
         if (rd_vld) begin
            chk("vld_after_ready", s_rdy, 1);
            chk("vld_in_pkt", in_pkt, 1);
            if (q.size() == 0) begin
               tests++; fails++;
               $display("FAIL beat_from_empty: got beat %0h want none", rd_data);
            end else begin
               m_ent = q.pop_front();
               chk("data", rd_data, m_ent[15:0]);
               if (m_beats == 0) m_hdr = m_ent[15:0];
               m_beats++;
               if (m_ent[16]) begin
                  eop_due = 1;
                  exp_le  = (m_beats != int'(m_hdr[15:7]));
               end
            end
         end
         if (s_v && m_occ < DEPTH) q.push_back({s_e, s_d});
      end
   end

   // ---------------- drivers ----------------
   task automatic push(input logic [15:0] d, input logic e);
      @(negedge clk);
      xfer_data_vld = 1'b1; xfer_data = d; end_of_packet = e;
   endtask

   task automatic idle_in();
      @(negedge clk);
      xfer_data_vld = 1'b0; end_of_packet = 1'b0;
   endtask

   task automatic wait_pkts(input int n, input int budget);
      int k = 0;
      while (pkts_done < n && k < budget) begin @(posedge clk); k++; end
      #2;
      chk("pkt_timeout", pkts_done >= n, 1);
   endtask

   typedef struct {int len; int nb; int dest; bit le;} vec_t;
   vec_t vt[8];
   logic [3:0] stall_tab [9] = '{4'b1100, 4'b1010, 4'b0000, 4'b0000, 4'b1010,
                                 4'b1010, 4'b1010, 4'b1001, 4'b1000};
   logic [2:0] b2b_tab [6] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, nv;
      logic [16:0] pend[$];
      logic [16:0] ent;

      vt[0] = '{4, 4, 5, 1'b0};   vt[1] = '{3, 4, 2, 1'b1};
      vt[2] = '{1, 1, 7, 1'b0};   vt[3] = '{0, 1, 3, 1'b1};
      vt[4] = '{0, 3, 1, 1'b1};   vt[5] = '{2, 2, 15, 1'b0};
      vt[6] = '{9, 8, 0, 1'b1};   vt[7] = '{8, 8, 12, 1'b0};

      repeat (3) @(negedge clk);
      rst = 1'b0; rd_ready = 1'b1;
      repeat (2) @(negedge clk);

      // latency from push into an empty FIFO
      push(hdr_w(1, 6), 1'b1);
      idle_in();
      chk("lat_sop_e0", rd_sop, 0);
      @(posedge clk); #1;
      chk("lat_sop_e1", rd_sop, 1); chk("lat_vld_e1", rd_vld, 0);
      @(posedge clk); #1;
      chk("lat_vld_e2", rd_vld, 1); chk("lat_sop_e2", rd_sop, 0);
      chk("lat_data_e2", rd_data, hdr_w(1, 6));
      @(posedge clk); #1;
      chk("lat_eop_e3", rd_eop, 1); chk("lat_le_e3", len_err, 0);
      repeat (2) @(negedge clk);

      // header / beat-count table
      for (int i = 0; i < 8; i++) begin
         base = pkts_done;
         push(hdr_w(vt[i].len, vt[i].dest), vt[i].nb == 1);
         for (int j = 1; j < vt[i].nb; j++) push(16'($urandom), j == vt[i].nb - 1);
         idle_in();
         wait_pkts(base + 1, 200);
         chk("vec_len_err", last_le, vt[i].le);
         chk("vec_dest", last_dest, vt[i].dest);
         chk("vec_beats", last_beats, vt[i].nb);
      end

      // stall inside DATA
      @(negedge clk); rd_ready = 1'b0;
      push(hdr_w(4, 3), 1'b0);
      push(16'h1111, 1'b0); push(16'h2222, 1'b0); push(16'h3333, 1'b1);
      idle_in();
      repeat (2) @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk); rd_ready = stall_tab[i][3];
         @(posedge clk); #1;
         chk("stall_sop", rd_sop, stall_tab[i][2]);
         chk("stall_vld", rd_vld, stall_tab[i][1]);
         chk("stall_eop", rd_eop, stall_tab[i][0]);
      end

      // fill, pause and overflow
      @(negedge clk); rd_ready = 1'b0;
      base = pkts_done;
      for (int i = 1; i <= 64; i++) begin
         push(i == 1 ? hdr_w(64, 9) : 16'($urandom), i == 64);
         @(posedge clk); #1;
         chk("fill_pause", xfer_pause, i >= 62);
      end
      push(16'h1234, 1'b0);
      @(posedge clk); #1;
      chk("fill_ovf", ovf, 1);
      idle_in();
      @(negedge clk); rd_ready = 1'b1;
      wait_pkts(base + 1, 400);
      chk("fill_beats", last_beats, 64);
      chk("fill_len_err", last_le, 0);
      chk("fill_dest", last_dest, 9);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("ovf_cleared", ovf, 0);

      // back-to-back single-beat packets
      push(hdr_w(1, 4), 1'b1);
      push(hdr_w(1, 11), 1'b1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin xfer_data_vld = 1'b0; end_of_packet = 1'b0; end
         chk("b2b_sop", rd_sop, b2b_tab[i][2]);
         chk("b2b_vld", rd_vld, b2b_tab[i][1]);
         chk("b2b_eop", rd_eop, b2b_tab[i][0]);
         chk("b2b_len_err", len_err, 0);
      end
      repeat (2) @(negedge clk);

      // reset after the second beat of an 8-beat packet
      @(negedge clk); rd_ready = 1'b0;
      push(hdr_w(8, 13), 1'b0);
      for (int j = 1; j < 8; j++) push(16'($urandom), j == 7);
      idle_in();
      @(negedge clk); rd_ready = 1'b1;
      nv = 0;
      for (int k = 0; k < 20 && nv < 2; k++) begin
         @(posedge clk); #1;
         if (rd_vld) nv++;
      end
      chk("rst_mid_beats", nv, 2);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_mid_dest", rd_dest, 0);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         chk("post_rst_sop", rd_sop, 0);
         chk("post_rst_vld", rd_vld, 0);
         chk("post_rst_eop", rd_eop, 0);
      end

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (pend.size() == 0) begin
            int nb, hl;
            nb = $urandom_range(1, 8);
            hl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : nb;
            pend.push_back({nb == 1, hdr_w(hl, $urandom_range(0, 15))});
            for (int j = 1; j < nb; j++) pend.push_back({j == nb - 1, 16'($urandom)});
         end
         rd_ready = (c >= 1000 && c < 1080) ? 1'b0 : ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) != 0) begin
            ent = pend.pop_front();
            xfer_data_vld = 1'b1; xfer_data = ent[15:0]; end_of_packet = ent[16];
         end else begin
            xfer_data_vld = 1'b0; end_of_packet = 1'b0;
         end
      end
      while (pend.size() != 0) begin
         ent = pend.pop_front();
         push(ent[15:0], ent[16]);
      end
      idle_in();
      rd_ready = 1'b1;
      for (int k = 0; k < 2000 && (q.size() != 0 || in_pkt || eop_due); k++) @(posedge clk);
      repeat (3) @(posedge clk);
      #2;
      chk("drain_empty", q.size(), 0);
      chk("drain_idle", in_pkt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/port_rd_frontend.md
# port_rd_frontend

Read-side port frontend: receives a packet's half-words from the read backend, buffers them in a 64-entry FIFO, and replays them to the external port. The external framing is a one-cycle `rd_sop`, a run of `rd_vld` beats with gaps allowed, then a one-cycle `rd_eop`. It is the egress counterpart of the write frontend and uses the same framing and header layout: first half-word `[15:7]` holds the packet length in half-words and `[3:0]` holds the port. The block also applies backpressure to the backend and checks each packet's length against its header.

## Interface
- `DEPTH`, 64: FIFO entries. Must be a power of two.
- `PAUSE_TH`, 61: occupancy at or above which `xfer_pause` asserts.
- `clk`  in  1: the single clock.
- `rst`  in  1: synchronous, active-high reset.
- `xfer_data_vld`  in  1: backend half-word valid. Push on this cycle.
- `xfer_data`  in  16: backend half-word.
- `end_of_packet`  in  1: qualifies `xfer_data` as the last half-word of its packet.
- `xfer_pause`  out  1: registered backpressure to the backend. Reset 0.
- `rd_ready`  in  1: external side can accept beats.
- `rd_sop`  out  1: start-of-packet pulse. Reset 0.
- `rd_vld`  out  1: `rd_data` is valid. Reset 0.
- `rd_data`  out  16: outgoing half-word. Reset 0.
- `rd_eop`  out  1: end-of-packet pulse, one cycle after the last beat. Reset 0.
- `rd_dest`  out  4: header `[3:0]` of the current packet. Reset 0.
- `len_err`  out  1: pulses together with `rd_eop` when the beat count differs from the header length. Reset 0.
- `ovf`  out  1: sticky; set when a push is attempted while the FIFO is full. Reset 0.

## Operation
- **FIFO:** 17-bit entries holding `{end_of_packet, xfer_data}`. Read and write pointers are `log2(DEPTH)` bits and wrap naturally. Count is `log2(DEPTH)+1` bits.
- **Push:** occurs when `xfer_data_vld` is high and count < `DEPTH`.
  - A push while full is dropped and sets `ovf`.
  - Push and pop on the same edge leave count unchanged.
- **FSM states:** IDLE, DATA, EOP.
  - IDLE → DATA when count > 0 and `rd_ready`. On that edge, register `rd_sop` = 1.
  - DATA: each edge with count > 0 and `rd_ready`, pop one entry, set `rd_vld` = 1 and `rd_data` = entry. Otherwise `rd_vld` = 0 and `rd_data` holds its value (gap).
  - DATA → EOP on the edge that pops an entry with the end tag set.
  - EOP → IDLE unconditionally. On that edge, register `rd_eop` = 1 and `len_err`.
- **Header capture:** the first pop of a packet captures `hdr_len` = `[15:7]` (9 bits) and `rd_dest` = `[3:0]`.
- **Beat counter:** a 9-bit counter is cleared in IDLE and incremented per pop.
  - On the tagged pop, `len_err` is computed as (count including this pop) ≠ `hdr_len`.
  - `hdr_len` = 0 always produces `len_err`.
- **Single-entry packet:** a packet that is one tagged entry is both header and last beat. It goes DATA → EOP after one beat.
- **Backpressure:** `xfer_pause` is registered as (count ≥ `PAUSE_TH`). The three-slot margin absorbs the backend's reaction latency.
- **Reset:** `rst` mid-packet clears pointers, count, FSM and all outputs on the next edge. The packet in flight is lost and no `rd_eop` is issued.

## Timing
- All outputs are registered.
- Push at edge E0 into an empty FIFO with `rd_ready` high:
  - `rd_sop` is high after E1.
  - The first `rd_vld` is high after E2.
- Tagged entry popped at edge Ek:
  - The last beat is visible after Ek.
  - `rd_eop` and `len_err` are valid after Ek+1.
  - The earliest next `rd_sop` is after Ek+2.
- `rd_ready` low when sampled at an edge means no beat in the following cycle. There is no skid; the external side accepts every `rd_vld` beat.
- `rd_sop` and `rd_eop` pulse for exactly one cycle. `rd_sop` is never concurrent with `rd_vld`.

## Structure
- **Shared package `hydra_pkg`:**
  - Constants: `HW_W` = 16, `LEN_MSB` = 15, `LEN_LSB` = 7, `PORT_W` = 4.
  - FSM enum `rd_state_t` {IDLE, DATA, EOP}.
- **Sub-module `port_rd_fifo`:** synchronous FIFO with pointers, count, the full/empty flags and the overflow detect. The FSM, header capture and length check stay in the top module.

## Test plan
- **Basic packet:** push 4 half-words, header 0x0205 (length 4, dest 5), last one tagged, `rd_ready` = 1.
  - Expect `rd_sop` one cycle, then 4 consecutive `rd_vld` beats with the same data, then `rd_eop`.
  - Expect `rd_dest` = 5 and `len_err` = 0.
- **Length mismatch:** header length 3 but 4 beats sent. Expect `len_err` = 1 in the `rd_eop` cycle.
- **Stall:** toggle `rd_ready` 1,0,0,1 during DATA. Expect a 2-cycle gap in `rd_vld`, no beat lost or duplicated, and `rd_sop`/`rd_eop` still single pulses.
- **Fill and overflow:** hold `rd_ready` = 0 and push 64 words.
  - Expect `xfer_pause` = 1 the cycle after count reaches 61.
  - Then push a 65th word. Expect `ovf` = 1 and the FIFO contents intact.
- **Back-to-back packets:** two 1-beat packets pushed consecutively. Expect `rd_sop`, `rd_vld`, `rd_eop`, `rd_sop`, `rd_vld`, `rd_eop` with `len_err` = 0 when headers carry length 1.
- **Reset mid-packet:** assert `rst` after the second beat of an 8-beat packet. The next cycle must show all outputs 0, count 0, and no `rd_eop`.
